// File: rtl/stack_mem_pkg.sv
// stack_mem_pkg: shared FSM state type and default geometry for the stack memory responder
package stack_mem_pkg;
  localparam int DEF_DEPTH  = 1020;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RDLAT} state_t;
endpackage

// File: rtl/stack_mem_bram.sv
// stack_mem_bram: inferred single-port block RAM, read data valid READ_LAT cycles after the read edge
module stack_mem_bram #(
  parameter int DEPTH    = 1020,
  parameter int DATA_W   = 32,
  parameter int AW       = 10,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] pipe [READ_LAT];
  // port access plus output pipeline; no reset so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
    if (en && !we) pipe[0] <= mem[addr];
    for (int i = READ_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
  end
  assign rdata = pipe[READ_LAT-1];
endmodule

// File: rtl/stack_mem_responder.sv
// stack_mem_responder: toggle req/ack responder in front of a block RAM; STACK_MEM_STATS_EN adds access counters
module stack_mem_responder
  import stack_mem_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int READ_LAT    = 1,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_tgl,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ack_tgl,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              err
`ifdef STACK_MEM_STATS_EN
  ,
  output logic [31:0]       stat_rd_cnt,
  output logic [31:0]       stat_wr_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(READ_LAT + 1);
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LAT - 1);
  state_t state, state_nx;
  logic lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0] wait_cnt;
  logic [LW-1:0] lat_cnt;
  logic [DATA_W-1:0] ram_rdata;
  logic pending, oor, ram_en, wr_done, rd_done, done;
  assign pending = req_tgl != ack_tgl;
  assign oor     = lat_addr >= ADDR_W'(DEPTH);
  assign ram_en  = state == S_ACCESS && !oor;
  assign wr_done = state == S_ACCESS && lat_we;
  assign rd_done = state == S_RDLAT && lat_cnt == LAT_LAST;
  assign done    = wr_done || rd_done;
  stack_mem_bram #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW), .READ_LAT(READ_LAT)
  ) u_bram (
    .clk(clk),
    .en(ram_en),
    .we(lat_we),
    .addr(lat_addr[AW-1:0]),
    .wdata(lat_wdata),
    .rdata(ram_rdata)
  );
  // state register; reset abandons any in-flight access before it reaches the RAM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else state <= state_nx;
  end
  // next state: optional wait states, then one access, then read latency for reads
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = pending ? (WAIT_STATES > 0 ? S_WAIT : S_ACCESS) : S_IDLE;
      S_WAIT:   state_nx = wait_cnt == WS_LAST ? S_ACCESS : S_WAIT;
      S_ACCESS: state_nx = lat_we ? S_IDLE : S_RDLAT;
      S_RDLAT:  state_nx = rd_done ? S_IDLE : S_RDLAT;
    endcase
  end
  // operand latch, counters, completion toggle, read data and sticky range error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
      lat_cnt   <= '0;
      ack_tgl   <= 1'b0;
      rsp_rdata <= '0;
      err       <= 1'b0;
    end else begin
      if (state == S_IDLE && pending) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      wait_cnt <= state == S_WAIT ? wait_cnt + 4'd1 : '0;
      lat_cnt  <= state == S_RDLAT ? lat_cnt + LW'(1) : '0;
      if (done) begin
        ack_tgl <= ~ack_tgl;
        err     <= err | oor;
      end
      if (rd_done) rsp_rdata <= oor ? '0 : ram_rdata;
    end
  end
`ifdef STACK_MEM_STATS_EN
  // saturating completion counters, bumped on the ack edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else begin
      if (rd_done && stat_rd_cnt != '1) stat_rd_cnt <= stat_rd_cnt + 32'd1;
      if (wr_done && stat_wr_cnt != '1) stat_wr_cnt <= stat_wr_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_stack_mem_responder.sv
// tb_stack_mem_responder: directed scoreboard bench, default instance plus a WAIT_STATES=3/READ_LAT=2 instance
module tb_stack_mem_responder;
  logic clk = 0;
  logic rst_n = 0;
  logic [1:0] req_tgl = '0;
  logic [1:0] req_we = '0;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [1:0] ack;
  logic [31:0] rsp [2];
  logic [1:0] err;
`ifdef STACK_MEM_STATS_EN
  logic [31:0] rd_cnt [2];
  logic [31:0] wr_cnt [2];
`endif
  int checks = 0;
  int failures = 0;
  logic [31:0] model [2][1024];
  logic [31:0] last [2];
  int exp_rd [2];
  int exp_wr [2];
  logic [31:0] sb [$];
  always #5 clk = ~clk;
  stack_mem_responder dut (
    .clk(clk), .reset(rst_n), .req_tgl(req_tgl[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .ack_tgl(ack[0]),
    .rsp_rdata(rsp[0]), .err(err[0])
`ifdef STACK_MEM_STATS_EN
    , .stat_rd_cnt(rd_cnt[0]), .stat_wr_cnt(wr_cnt[0])
`endif
  );
  stack_mem_responder #(.READ_LAT(2), .WAIT_STATES(3)) dut_w (
    .clk(clk), .reset(rst_n), .req_tgl(req_tgl[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .ack_tgl(ack[1]),
    .rsp_rdata(rsp[1]), .err(err[1])
`ifdef STACK_MEM_STATS_EN
    , .stat_rd_cnt(rd_cnt[1]), .stat_wr_cnt(wr_cnt[1])
`endif
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat);
    int k;
    logic prev;
    logic [31:0] e;
    if (we) begin
      if (addr < 1020) model[d][addr] = wdata;
      e = last[d];
      exp_wr[d]++;
    end else begin
      e = addr < 1020 ? model[d][addr] : 32'h0;
      exp_rd[d]++;
    end
    last[d] = e;
    sb.push_back(e);
    @(negedge clk);
    req_we[d] = we;
    req_addr[d] = addr;
    req_wdata[d] = wdata;
    prev = ack[d];
    req_tgl[d] = ~req_tgl[d];
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (ack[d] == prev && k < 40);
    check($sformatf("ack_flip d%0d a%0d", d, addr), 32'(ack[d] != prev), 32'd1);
    check($sformatf("latency d%0d a%0d", d, addr), 32'(k - 1), 32'(exp_lat));
    check($sformatf("rsp d%0d a%0d", d, addr), rsp[d], sb.pop_front());
    check($sformatf("ack_eq_req d%0d", d), 32'(ack[d]), 32'(req_tgl[d]));
  endtask
  task automatic check_stats(input string tag);
`ifdef STACK_MEM_STATS_EN
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s rd_cnt d%0d", tag, d), rd_cnt[d], 32'(exp_rd[d]));
      check($sformatf("%s wr_cnt d%0d", tag, d), wr_cnt[d], 32'(exp_wr[d]));
    end
`else
    checks += 0;
`endif
  endtask
  initial begin
    req_addr[0] = '0; req_addr[1] = '0;
    req_wdata[0] = '0; req_wdata[1] = '0;
    last[0] = '0; last[1] = '0;
    exp_rd[0] = 0; exp_rd[1] = 0; exp_wr[0] = 0; exp_wr[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset ack d%0d", d), 32'(ack[d]), 32'd0);
      check($sformatf("reset rsp d%0d", d), rsp[d], 32'd0);
      check($sformatf("reset err d%0d", d), 32'(err[d]), 32'd0);
    end
    check_stats("reset");
    @(negedge clk);
    rst_n = 1;
    xfer(0, 1, 5, 32'h3F80_0000, 1);
    xfer(0, 0, 5, 32'h0, 2);
    check("err after in-range", 32'(err[0]), 32'd0);
    xfer(1, 1, 0, 32'h1234_5678, 4);
    xfer(1, 0, 0, 32'h0, 6);
    xfer(0, 1, 1020, 32'hDEAD_BEEF, 1);
    check("err after oor write", 32'(err[0]), 32'd1);
    xfer(0, 0, 1020, 32'h0, 2);
    xfer(0, 0, 5, 32'h0, 2);
    check("err sticky", 32'(err[0]), 32'd1);
    xfer(0, 1, 32'hFFFF_FFFF, 32'h5555_AAAA, 1);
    for (int a = 0; a < 30; a++) xfer(0, 1, a, $urandom, 1);
    for (int a = 0; a < 30; a++) xfer(0, 0, a, 32'h0, 2);
    check_stats("traffic");
    xfer(1, 1, 7, 32'h0000_1111, 4);
    xfer(1, 0, 7, 32'h0, 6);
    @(negedge clk);
    req_we[1] = 1;
    req_addr[1] = 7;
    req_wdata[1] = 32'h0000_2222;
    req_tgl[1] = ~req_tgl[1];
    repeat (2) @(negedge clk);
    rst_n = 0;
    req_tgl = '0;
    #1;
    check("midreset ack d1", 32'(ack[1]), 32'd0);
    check("midreset rsp d1", rsp[1], 32'd0);
    check("midreset err d0", 32'(err[0]), 32'd0);
    last[0] = '0; last[1] = '0;
    exp_rd[0] = 0; exp_rd[1] = 0; exp_wr[0] = 0; exp_wr[1] = 0;
    check_stats("midreset");
    repeat (6) @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    check("idle after release d1", 32'(ack[1]), 32'd0);
    xfer(1, 0, 7, 32'h0, 6);
    xfer(0, 0, 5, 32'h0, 2);
    xfer(0, 1, 3, 32'hCAFE_F00D, 1);
    xfer(0, 0, 3, 32'h0, 2);
    check_stats("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
